// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiplier / multiply-accumulate for generated dense layers.
// A product is formed at the input, carried through NUM_STAGE-1 registers and
// consumed by the final stage. That stage either forwards it (MODE 0) or adds it
// into a saturating accumulator (MODE 1), then shifts and saturates the result
// to dout_WIDTH.
module myproject_mac_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 12,
   parameter int din1_WIDTH = 6,
   parameter int ACC_WIDTH  = 24,
   parameter int dout_WIDTH = 18,
   parameter int FRAC_SHIFT = 0,
   parameter int MODE       = 0,
   parameter int ACC_LEN    = 4
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         ce,
   input  logic                         din_vld,
   input  logic                         acc_clr,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   output logic                         dout_vld,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic                         ovf
);

   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

   generate
      if (ID < 0 || NUM_STAGE < 1 || din0_WIDTH < 1 || din1_WIDTH < 1 || dout_WIDTH < 1 ||
          ACC_WIDTH < PW || FRAC_SHIFT < 0 || FRAC_SHIFT >= ACC_WIDTH ||
          !(MODE == 0 || MODE == 1) || ACC_LEN < 1) begin : g_bad_param
         $fatal(1, "myproject_mac_pipe: illegal parameter combination");
      end
   endgenerate

   // Full-precision product; both operands are sign-extended before the multiply.
   logic signed [PW-1:0] prod;
   assign prod = PW'(din0) * PW'(din1);

   logic                 fin_vld;
   logic                 fin_clr;
   logic signed [PW-1:0] fin_p;

   generate
      if (NUM_STAGE == 1) begin : g_direct
         assign fin_vld = din_vld;
         assign fin_clr = acc_clr;
         assign fin_p   = prod;
      end else begin : g_pipe
         logic                 pl_vld [NUM_STAGE-1];
         logic                 pl_clr [NUM_STAGE-1];
         logic signed [PW-1:0] pl_p   [NUM_STAGE-1];

         // Delay line carrying the product, its valid bit and the clear marker
         // so a clear lines up with the terms issued around it.
         always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
               for (int i = 0; i < NUM_STAGE-1; i++) begin
                  pl_vld[i] <= 1'b0;
                  pl_clr[i] <= 1'b0;
                  pl_p[i]   <= '0;
               end
            end else if (ce) begin
               pl_vld[0] <= din_vld;
               pl_clr[0] <= acc_clr;
               pl_p[0]   <= prod;
               for (int i = 1; i < NUM_STAGE-1; i++) begin
                  pl_vld[i] <= pl_vld[i-1];
                  pl_clr[i] <= pl_clr[i-1];
                  pl_p[i]   <= pl_p[i-1];
               end
            end
         end

         assign fin_vld = pl_vld[NUM_STAGE-2];
         assign fin_clr = pl_clr[NUM_STAGE-2];
         assign fin_p   = pl_p[NUM_STAGE-2];
      end
   endgenerate

   logic signed [ACC_WIDTH-1:0] acc;
   logic        [CW-1:0]        cnt;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic        [CW-1:0]        cnt_base;
   logic signed [ACC_WIDTH-1:0] p_ext;
   logic signed [ACC_WIDTH:0]   sum;
   logic signed [ACC_WIDTH-1:0] acc_sat;
   logic signed [ACC_WIDTH-1:0] x_sel;
   logic                        acc_of;
   logic                        last;
   logic                        emit;

   // Final-stage arithmetic: clear first, then the saturating add of the arriving term.
   always_comb begin
      acc_base = fin_clr ? '0 : acc;
      cnt_base = fin_clr ? '0 : cnt;
      p_ext    = ACC_WIDTH'(fin_p);
      sum      = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(p_ext);
      acc_of   = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
      acc_sat  = acc_of ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}}
                        : sum[ACC_WIDTH-1:0];
      last     = (cnt_base == CW'(ACC_LEN-1));
      x_sel    = (MODE == 0) ? p_ext : acc_sat;
      emit     = fin_vld && ((MODE == 0) || last);
   end

   logic signed [ACC_WIDTH-1:0]  x_sh;
   logic signed [dout_WIDTH-1:0] r_val;
   logic                         r_of;

   // Arithmetic shift truncates toward -inf.
   assign x_sh = x_sel >>> FRAC_SHIFT;

   generate
      if (dout_WIDTH >= ACC_WIDTH) begin : g_wide
         assign r_val = dout_WIDTH'(x_sh);
         assign r_of  = 1'b0;
      end else begin : g_narrow
         // The value fits when every bit from the dout sign bit upward agrees.
         logic [ACC_WIDTH-dout_WIDTH:0] hi;
         assign hi    = x_sh[ACC_WIDTH-1:dout_WIDTH-1];
         assign r_of  = !((&hi) || !(|hi));
         assign r_val = r_of ? {x_sh[ACC_WIDTH-1], {(dout_WIDTH-1){~x_sh[ACC_WIDTH-1]}}}
                             : x_sh[dout_WIDTH-1:0];
      end
   endgenerate

   // Output register, accumulator and sticky overflow; all frozen while ce=0.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         acc      <= '0;
         cnt      <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         ovf      <= 1'b0;
      end else if (ce) begin
         dout_vld <= emit;
         if (emit) begin
            dout <= r_val;
         end
         if (emit && r_of) begin
            ovf <= 1'b1;
         end
         if ((MODE != 0) && fin_vld && acc_of) begin
            ovf <= 1'b1;
         end
         if ((MODE == 0) || emit) begin
            acc <= '0;
            cnt <= '0;
         end else if (fin_vld) begin
            acc <= acc_sat;
            cnt <= cnt_base + 1'b1;
         end else begin
            acc <= acc_base;
            cnt <= cnt_base;
         end
      end
   end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: three instances share one stimulus stream.
//   inst0: MODE 0, dout 16 bits, 3 stages
//   inst1: MODE 0, shift 2, dout 10 bits, 1 stage
//   inst2: MODE 1, ACC_LEN 4, acc 18 bits, 3 stages
// Expected results come from an integer model and are queued when a term is
// issued; a monitor pops them whenever an instance presents a result.
module tb_myproject_mac_pipe;

   logic               ap_clk;
   logic               ap_rst;
   logic               ce;
   logic               din_vld;
   logic               acc_clr;
   logic signed [11:0] din0;
   logic signed [5:0]  din1;

   logic               vld_a, vld_b, vld_c;
   logic               ovf_a, ovf_b, ovf_c;
   logic signed [15:0] dout_a;
   logic signed [9:0]  dout_b;
   logic signed [17:0] dout_c;

   myproject_mac_pipe #(.NUM_STAGE(3), .dout_WIDTH(16), .FRAC_SHIFT(0), .MODE(0)) u_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld), .acc_clr(acc_clr),
      .din0(din0), .din1(din1), .dout_vld(vld_a), .dout(dout_a), .ovf(ovf_a));

   myproject_mac_pipe #(.NUM_STAGE(1), .dout_WIDTH(10), .FRAC_SHIFT(2), .MODE(0)) u_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld), .acc_clr(acc_clr),
      .din0(din0), .din1(din1), .dout_vld(vld_b), .dout(dout_b), .ovf(ovf_b));

   myproject_mac_pipe #(.NUM_STAGE(3), .ACC_WIDTH(18), .dout_WIDTH(18), .FRAC_SHIFT(0),
                        .MODE(1), .ACC_LEN(4)) u_c (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld), .acc_clr(acc_clr),
      .din0(din0), .din1(din1), .dout_vld(vld_c), .dout(dout_c), .ovf(ovf_c));

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      longint v;
      bit     o;
      longint e;
   } exp_t;

   exp_t   q [3][$];
   int     n_chk  = 0;
   int     n_fail = 0;
   int     ecnt   = 0;
   longint acc_m  = 0;
   int     cnt_m  = 0;
   bit     ovf_m [3];

   function automatic void chk(string nm, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic longint clamp(longint x, int w, output bit of);
      longint lim;
      lim = longint'(1) << (w-1);
      of  = 1'b0;
      if (x > lim-1) begin
         of = 1'b1;
         return lim-1;
      end
      if (x < -lim) begin
         of = 1'b1;
         return -lim;
      end
      return x;
   endfunction

   function automatic longint xform(longint x, int fs, int dw, output bit of);
      return clamp(x >>> fs, dw, of);
   endfunction

   function automatic void push(int k, longint r, int lat);
      exp_t e;
      e.v = r;
      e.o = ovf_m[k];
      e.e = longint'(ecnt + lat);
      q[k].push_back(e);
   endfunction

   // Reference behaviour for one accepted cycle (ce=1, no reset).
   function automatic void model_accept(int a, int b, bit clr, bit v);
      longint p, r, s;
      bit     of;
      if (clr) begin
         acc_m = 0;
         cnt_m = 0;
      end
      if (v) begin
         p = longint'(a) * longint'(b);
         r = xform(p, 0, 16, of);
         ovf_m[0] |= of;
         push(0, r, 3);
         r = xform(p, 2, 10, of);
         ovf_m[1] |= of;
         push(1, r, 1);
         s = clamp(acc_m + p, 18, of);
         ovf_m[2] |= of;
         cnt_m++;
         if (cnt_m == 4) begin
            r = xform(s, 0, 18, of);
            ovf_m[2] |= of;
            push(2, r, 3);
            acc_m = 0;
            cnt_m = 0;
         end else begin
            acc_m = s;
         end
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         q[k].delete();
         ovf_m[k] = 1'b0;
      end
      acc_m = 0;
      cnt_m = 0;
   endfunction

   task automatic step(input bit c, input bit v, input bit clr, input int a, input int b);
      ce      = c;
      din_vld = v;
      acc_clr = clr;
      din0    = 12'(a);
      din1    = 6'(b);
      if (c && !ap_rst) model_accept(a, b, clr, v);
      @(posedge ap_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      model_reset();
      #1;
      chk("reset dout inst0", longint'(dout_a), 0);
      chk("reset dout inst1", longint'(dout_b), 0);
      chk("reset dout inst2", longint'(dout_c), 0);
      chk("reset dout_vld inst0", longint'(vld_a), 0);
      chk("reset dout_vld inst1", longint'(vld_b), 0);
      chk("reset dout_vld inst2", longint'(vld_c), 0);
      chk("reset ovf inst0", longint'(ovf_a), 0);
      chk("reset ovf inst1", longint'(ovf_b), 0);
      chk("reset ovf inst2", longint'(ovf_c), 0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b0;
   endtask

   task automatic mon(input int k, input longint d, input logic v, input logic o);
      exp_t e;
      if (v) begin
         if (q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected result inst%0d: got dout=%0d, expected no result", k, d);
         end else begin
            e = q[k].pop_front();
            chk($sformatf("dout inst%0d", k), d, e.v);
            chk($sformatf("ovf inst%0d", k), longint'(o), longint'(e.o));
            chk($sformatf("latency edge inst%0d", k), longint'(ecnt), e.e);
         end
      end
   endtask

   // Monitor: a result is presented when dout_vld is high after an enabled edge.
   initial begin : monitor
      bit ce_s;
      forever begin
         @(posedge ap_clk);
         ce_s = ce;
         if (ce) ecnt++;
         @(negedge ap_clk);
         if (!ap_rst && ce_s) begin
            mon(0, longint'(dout_a), vld_a, ovf_a);
            mon(1, longint'(dout_b), vld_b, ovf_b);
            mon(2, longint'(dout_c), vld_c, ovf_c);
         end
      end
   end

   initial begin : stim
      int a, b;
      bit c, v, clr;
      ap_rst  = 1'b0;
      ce      = 1'b0;
      din_vld = 1'b0;
      acc_clr = 1'b0;
      din0    = '0;
      din1    = '0;
      #2;
      do_reset();

      // Back-to-back products.
      step(1, 1, 0, 100, -3);
      step(1, 1, 0, -7, 5);
      idle(4);

      // Saturation and truncating shift.
      step(1, 1, 0, -2048, -32);
      step(1, 1, 0, -7, 1);
      idle(4);

      // Accumulation with bubbles, then a second independent sum.
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 10, 2);
      idle(1);
      step(1, 1, 0, -5, 3);
      idle(1);
      step(1, 1, 0, 7, -1);
      idle(1);
      step(1, 1, 0, 1, 1);
      step(1, 1, 0, 3, 3);
      step(1, 1, 0, -4, 2);
      step(1, 1, 0, 6, -6);
      step(1, 1, 0, 11, 1);
      idle(4);

      // Stream with a 5-cycle stall; held inputs during the stall are ignored.
      for (int i = 0; i < 8; i++) begin
         if (i == 4) repeat (5) step(0, 1, 1, 999, 7);
         step(1, 1, 0, i*37 - 120, i - 3);
      end
      idle(4);

      // Reset in the middle of a partial sum.
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 9, 9);
      step(1, 1, 0, -9, 9);
      #3;
      do_reset();
      step(1, 1, 0, 2, 2);
      step(1, 1, 0, 3, 3);
      step(1, 1, 0, 4, 4);
      step(1, 1, 0, 5, 5);
      idle(4);

      // Clear coinciding with a term.
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 5, 6);
      step(1, 1, 0, 2, -3);
      step(1, 1, 0, 7, 7);
      step(1, 1, 1, 4, 4);
      step(1, 1, 0, 1, 1);
      step(1, 1, 0, 1, 1);
      step(1, 1, 0, 1, 1);
      idle(4);

      // Randomised traffic with stalls, bubbles, clears and extreme operands.
      for (int i = 0; i < 600; i++) begin
         c   = ($urandom_range(0, 9) != 0);
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 1) != 0) ? -2048 : 2047;
            b = ($urandom_range(0, 1) != 0) ? -32 : 31;
         end else begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = int'($urandom_range(0, 63)) - 32;
         end
         step(c, v, clr, a, b);
      end

      idle(6);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("pending results inst%0d", k), longint'(q[k].size()), 0);
      end
      chk("final ovf inst0", longint'(ovf_a), longint'(ovf_m[0]));
      chk("final ovf inst1", longint'(ovf_b), longint'(ovf_m[1]));
      chk("final ovf inst2", longint'(ovf_c), longint'(ovf_m[2]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
